// File: rtl/rv32i_exec_unit.sv
// rv32i_exec_unit
//   Execute stage of the RV32I core. Takes the two register-file operands
//   (or operand A plus a sign-extended immediate) and performs the RV32I
//   integer ALU operation. Non-shift operations, and shifts by zero, give
//   a result in one cycle. Shifts by n > 0 move 1 bit per cycle and give
//   a result after 1+n cycles. The result goes to the register-file
//   write-back port.
//
// Ports
//   i_clk, i_rst          clock and synchronous active-high reset
//   i_valid / o_ready     accept handshake (o_ready depends only on state)
//   i_funct3, i_alt       operation select (i_alt = instruction bit 30)
//   i_is_imm              selects i_imm instead of i_rs2 as operand B
//   i_rs1, i_rs2, i_imm   operands
//   i_rd_addr             destination register
//   o_wb_we/addr/data     register-file write-back port
//   o_busy                an iterative shift is in progress
module rv32i_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [2:0]         i_funct3,
  input  logic               i_alt,
  input  logic               i_is_imm,
  input  logic [XLEN-1:0]    i_rs1,
  input  logic [XLEN-1:0]    i_rs2,
  input  logic [XLEN-1:0]    i_imm,
  input  logic [4:0]         i_rd_addr,
  output logic               o_wb_we,
  output logic [4:0]         o_wb_addr,
  output logic [XLEN-1:0]    o_wb_data,
  output logic               o_busy
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              state_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic [XLEN-1:0]     work_q;
  logic                left_q;
  logic                arith_q;
  logic [4:0]          rd_q;
  logic                wb_we_q;
  logic [4:0]          wb_addr_q;
  logic [XLEN-1:0]     wb_data_q;

  logic [XLEN-1:0]     op_b_d;
  logic [SHAMT_W-1:0]  shamt_d;
  logic                is_shift_d;
  logic                is_sub_d;
  logic [XLEN-1:0]     alu_res_d;
  logic [XLEN-1:0]     step_d;

  // Single-cycle ALU. Shift codes only reach here with a zero shift
  // amount, so they pass operand A through.
  function automatic logic [XLEN-1:0] alu(input logic [2:0]      f3,
                                          input logic            sub,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'b000:  alu = sub ? (a - b) : (a + b);
      3'b010:  alu = (sa < sb) ? XLEN'(1) : '0;
      3'b011:  alu = (a < b)   ? XLEN'(1) : '0;
      3'b100:  alu = a ^ b;
      3'b110:  alu = a | b;
      3'b111:  alu = a & b;
      default: alu = a;
    endcase
  endfunction

  // One bit of shift: left fills 0, right fills 0 or replicates the sign.
  function automatic logic [XLEN-1:0] shift1(input logic            left,
                                             input logic            arith,
                                             input logic [XLEN-1:0] v);
    if (left) shift1 = {v[XLEN-2:0], 1'b0};
    else      shift1 = {arith & v[XLEN-1], v[XLEN-1:1]};
  endfunction

  always_comb begin
    op_b_d     = i_is_imm ? i_imm : i_rs2;
    shamt_d    = op_b_d[SHAMT_W-1:0];
    is_shift_d = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    // ADDI has no SUB form even when bit 30 of the immediate is set.
    is_sub_d   = i_alt && !i_is_imm;
    alu_res_d  = alu(i_funct3, is_sub_d, i_rs1, op_b_d);
    step_d     = shift1(left_q, arith_q, work_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            if (is_shift_d && (shamt_d != '0)) begin
              work_q  <= i_rs1;
              left_q  <= (i_funct3 == 3'b001);
              arith_q <= i_alt;
              rd_q    <= i_rd_addr;
              cnt_q   <= shamt_d;
              state_q <= S_SHIFT;
            end else begin
              wb_data_q <= alu_res_d;
              wb_addr_q <= i_rd_addr;
              wb_we_q   <= (i_rd_addr != 5'd0);
            end
          end
        end
        S_SHIFT: begin
          work_q <= step_d;
          cnt_q  <= cnt_q - 1'b1;
          // Last bit: the shifted value is the result.
          if (cnt_q == SHAMT_W'(1)) begin
            wb_data_q <= step_d;
            wb_addr_q <= rd_q;
            wb_we_q   <= (rd_q != 5'd0);
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_busy    = (state_q == S_SHIFT);
  assign o_wb_we   = wb_we_q;
  assign o_wb_addr = wb_addr_q;
  assign o_wb_data = wb_data_q;

endmodule

// File: tb/tb_rv32i_exec_unit.sv
module tb_rv32i_exec_unit;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [2:0]  funct3;
  logic        alt;
  logic        is_imm;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  rv32i_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .o_ready   (ready),
    .i_funct3  (funct3),
    .i_alt     (alt),
    .i_is_imm  (is_imm),
    .i_rs1     (rs1),
    .i_rs2     (rs2),
    .i_imm     (imm),
    .i_rd_addr (rd),
    .o_wb_we   (wb_we),
    .o_wb_addr (wb_addr),
    .o_wb_data (wb_data),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic a_alt, input logic sel_imm,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] dst);
    valid  = 1'b1;
    funct3 = f3;
    alt    = a_alt;
    is_imm = sel_imm;
    rs1    = a;
    rs2    = b;
    imm    = im;
    rd     = dst;
  endtask

  // Single-cycle op: accept on the next edge, then check the write-back pulse.
  task automatic op1(input string tag, input logic [2:0] f3, input logic a_alt,
                     input logic sel_imm, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] im, input logic [4:0] dst, input logic [31:0] exp);
    drive(f3, a_alt, sel_imm, a, b, im, dst);
    tick();
    valid = 1'b0;
    chk({tag, "_we"},   {31'd0, wb_we}, 32'd1);
    chk({tag, "_addr"}, {27'd0, wb_addr}, {27'd0, dst});
    chk({tag, "_data"}, wb_data, exp);
    tick();
    chk({tag, "_pulse"}, {31'd0, wb_we}, 32'd0);
  endtask

  // Shift by n>0: ready low for n cycles, then a write-back pulse.
  task automatic opshift(input string tag, input logic [2:0] f3, input logic a_alt,
                         input logic [31:0] a, input logic [31:0] n, input logic [4:0] dst,
                         input logic [31:0] exp);
    drive(f3, a_alt, 1'b0, a, n, 32'd0, dst);
    tick();
    valid = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      chk({tag, "_rdy_low"}, {31'd0, ready}, 32'd0);
      chk({tag, "_we_low"},  {31'd0, wb_we}, 32'd0);
      tick();
    end
    chk({tag, "_we"},   {31'd0, wb_we}, 32'd1);
    chk({tag, "_addr"}, {27'd0, wb_addr}, {27'd0, dst});
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rdy"},  {31'd0, ready}, 32'd1);
    tick();
    chk({tag, "_pulse"}, {31'd0, wb_we}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3);
    tick();
    tick();
    chk("rst_we",   {31'd0, wb_we}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_rdy",  {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst   = 1'b0;
    valid = 1'b0;
    tick();
    chk("post_rst_we", {31'd0, wb_we}, 32'd0);

    op1("add",  3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 32'd12);
    op1("sub",  3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 5'd4, 32'hFFFF_FFFE);
    op1("addi", 3'b000, 1'b1, 1'b1, 32'd5, 32'd100, 32'd7, 5'd9, 32'd12);
    op1("slt",  3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd10, 32'd1);
    op1("sltu", 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd11, 32'd0);
    op1("xor",  3'b100, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd12, 32'h0000_0FF0);
    op1("or",   3'b110, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd13, 32'h0000_FFF0);
    op1("and",  3'b111, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd14, 32'h0000_F000);

    opshift("sra",   3'b101, 1'b1, 32'h8000_0000, 32'd4, 5'd5, 32'hF800_0000);
    opshift("srl",   3'b101, 1'b0, 32'h8000_0000, 32'd4, 5'd6, 32'h0800_0000);
    op1("slli0", 3'b001, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd9, 32'd0, 5'd7, 32'hDEAD_BEEF);
    opshift("sll31", 3'b001, 1'b0, 32'd1, 32'd31, 5'd8, 32'h8000_0000);

    // Write to x0: no enable, but address and data still update.
    drive(3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd0);
    tick();
    valid = 1'b0;
    chk("x0_we",   {31'd0, wb_we}, 32'd0);
    chk("x0_addr", {27'd0, wb_addr}, 32'd0);
    chk("x0_data", wb_data, 32'd3);
    tick();
    chk("x0_we2",  {31'd0, wb_we}, 32'd0);

    // Four back-to-back ADDs.
    for (int k = 0; k < 4; k++) begin
      drive(3'b000, 1'b0, 1'b0, 32'(100 * k), 32'd1, 32'd0, 5'(16 + k));
      tick();
      chk("b2b_we",   {31'd0, wb_we}, 32'd1);
      chk("b2b_addr", {27'd0, wb_addr}, 32'(16 + k));
      chk("b2b_data", wb_data, 32'(100 * k + 1));
    end
    valid = 1'b0;
    tick();
    chk("b2b_end_we", {31'd0, wb_we}, 32'd0);

    // Valid held high through a shift: next op accepted on the first ready edge.
    drive(3'b101, 1'b0, 1'b0, 32'h0000_0100, 32'd2, 32'd0, 5'd20);
    tick();
    drive(3'b000, 1'b0, 1'b0, 32'd10, 32'd20, 32'd0, 5'd21);
    chk("hold_rdy1", {31'd0, ready}, 32'd0);
    tick();
    chk("hold_rdy2", {31'd0, ready}, 32'd0);
    chk("hold_we2",  {31'd0, wb_we}, 32'd0);
    tick();
    chk("hold_sh_we",   {31'd0, wb_we}, 32'd1);
    chk("hold_sh_addr", {27'd0, wb_addr}, 32'd20);
    chk("hold_sh_data", wb_data, 32'h0000_0040);
    tick();
    valid = 1'b0;
    chk("hold_add_we",   {31'd0, wb_we}, 32'd1);
    chk("hold_add_addr", {27'd0, wb_addr}, 32'd21);
    chk("hold_add_data", wb_data, 32'd30);
    tick();
    chk("hold_end_we", {31'd0, wb_we}, 32'd0);

    // Reset three cycles into a 10-bit shift aborts it.
    drive(3'b001, 1'b0, 1'b0, 32'd1, 32'd10, 32'd0, 5'd22);
    tick();
    valid = 1'b0;
    tick();
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rdy",  {31'd0, ready}, 32'd1);
    chk("abort_busy0", {31'd0, busy}, 32'd0);
    chk("abort_data", wb_data, 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_we", {31'd0, wb_we}, 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_unit.md
Name: rv32i_exec_unit

Overview:
- Execute stage of the RV32I core. Sits directly downstream of the register file.
- Consumes the two source operands read from the register file, plus an optional immediate, and performs the RV32I integer ALU operation.
- Single-cycle operations complete in 1 cycle. Shifts run iteratively, 1 bit per cycle.
- Drives the register file write-back port (write enable, address, data).

Parameters:
- XLEN, 32, datapath width in bits. Only 32 is supported.
- SHAMT_W, 5, shift-amount width in bits. Equals log2(XLEN).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  an operation is presented this cycle.
- o_ready  out  1  block can accept an operation this cycle.
- i_funct3  in  3  RV32I funct3: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- i_alt  in  1  instruction bit 30; selects SUB and SRA/SRAI.
- i_is_imm  in  1  1 selects i_imm as operand B instead of i_rs2.
- i_rs1  in  32  operand A, from register file o_rs1.
- i_rs2  in  32  operand B, from register file o_rs2.
- i_imm  in  32  sign-extended immediate.
- i_rd_addr  in  5  destination register index.
- o_wb_we  out  1  write enable to the register file.
- o_wb_addr  out  5  write address to the register file.
- o_wb_data  out  32  write data to the register file.
- o_busy  out  1  an iterative shift is in progress.

Behaviour:
- Reset: i_rst sampled high at a clock edge forces the following next cycle:
  - state=IDLE, o_wb_we=0, o_wb_addr=0, o_wb_data=0, shift counter=0.
  - o_ready=1, o_busy=0.
- Reset wins over every other event. Reset during SHIFT aborts the operation; no write-back ever occurs for it.
- Handshake:
  - An operation is accepted at an edge where i_valid && o_ready.
  - o_ready = (state==IDLE). It is combinational from state only, not from i_valid.
  - While o_ready=0, inputs are ignored. The upstream stage must hold its inputs until accepted.
- Operand B = i_is_imm ? i_imm : i_rs2. Shift amount = B[4:0].
- SUB is performed only when funct3=000, i_alt=1 and i_is_imm=0. ADDI ignores i_alt.
- SLT is a signed compare; SLTU is unsigned. Result is 32'd1 or 32'd0.
- ADD/SUB wrap modulo 2^32. There is no overflow flag.
- State IDLE:
  - Non-shift accept (funct3 not 001/101): the result is registered at the accept edge.
  - o_wb_we=1 for exactly the next cycle; o_wb_addr=i_rd_addr.
  - State stays IDLE, so back-to-back accepts give 1 result per cycle.
- Shift accept with shamt=0: same as a non-shift op (latency 1); o_wb_data=A.
- Shift accept with shamt=n>0:
  - Latch A, direction, arithmetic flag and rd. Set counter=n; go to SHIFT.
  - Write-back is low in the following cycle unless it is carrying the previous op's result.
- State SHIFT:
  - Each edge shifts the working value by 1 bit and decrements the counter.
  - SLL fills with 0. SRL fills with 0. SRA replicates bit 31.
  - o_busy=1, o_ready=0, o_wb_we=0.
  - On the edge where the counter goes 1→0: register the result, o_wb_we=1 the next cycle, return to IDLE.
- Latency is 1+shamt cycles from the accept edge to the o_wb_we cycle. An accept may coincide with that write-back cycle.
- o_wb_we stays 0 whenever rd=0, with timing otherwise unchanged. o_wb_addr/o_wb_data still update.
- o_wb_we is a one-cycle pulse per accepted operation. o_wb_addr/o_wb_data hold their last value when o_wb_we=0.

Test Plan:
- Reset: assert i_rst 2 cycles with i_valid=1 → o_wb_we=0, o_wb_data=0, o_ready=1, o_busy=0, no write-back afterwards.
- ALU ops:
  - ADD A=5, B=7, rd=3 → next cycle o_wb_we=1, addr=3, data=12.
  - SUB 5−7 → 0xFFFFFFFE.
  - ADDI i_alt=1, A=5, imm=7 → 12.
- Compares: SLT A=0xFFFFFFFF, B=1 → 1; SLTU same operands → 0.
- Shifts:
  - SRA A=0x80000000, shamt=4 → o_ready=0 for 4 cycles, o_wb_we in cycle 5 after accept, data 0xF8000000.
  - SRL same → 0x08000000.
  - SLLI shamt=0 → latency 1, data=A.
  - shamt=31 SLL A=1 → 0x80000000 after 32 cycles.
- x0 and streaming:
  - ADD rd=0 → o_wb_we stays 0.
  - 4 back-to-back ADDs → 4 consecutive o_wb_we pulses, in order.
  - i_valid held high during a shift → the next op is accepted on the first ready edge.
- Reset during SHIFT: SLL shamt=10, assert i_rst 3 cycles after accept → no o_wb_we pulse, o_ready=1 the cycle after reset.
